// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and request record.
package load_store_unit_pkg;

    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        size_e             size;
        logic              sign;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Byte enables for the store data lanes; unused upper bytes are zeroed on the bus.
    function automatic logic [31:0] byte_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 32'h0000_00FF;
            SZ_HALF: return 32'h0000_FFFF;
            SZ_WORD: return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_addr.sv
// Per-lane byte addresses and range fault for one access of the load/store unit.
module lsu_lane_addr
    import load_store_unit_pkg::*;
#(
    parameter int MemSize = 125
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          size,
    output logic [4*ADDR_W-1:0] lane_addr,
    output logic                fault
);

    logic [2:0]        nbytes;
    logic [1:0]        top_lane;
    logic [ADDR_W:0]   last_byte;

    assign nbytes = size_bytes(size);

    always_comb begin
        top_lane = 2'd0;
        if (size != SZ_NONE) top_lane = 2'(nbytes - 3'd1);
    end

    // Unused lanes repeat the highest used lane so em_read stays in range near the top.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [1:0] off;
        assign off = (2'(g) > top_lane) ? top_lane : 2'(g);
        assign lane_addr[g*ADDR_W +: ADDR_W] = addr + ADDR_W'(off);
    end

    // One extra bit so the end address never wraps past 1023.
    assign last_byte = {1'b0, addr} + (ADDR_W+1)'(top_lane);
    assign fault     = (size != SZ_NONE) && (last_byte >= (ADDR_W+1)'(MemSize));

endmodule

// File: rtl/load_store_unit.sv
// Three-state load/store unit: accept a request, drive the memory bus for one cycle, respond.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MemSize = 125
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic [1:0]  em_control,
    output logic [39:0] em_address,
    output logic [31:0] em_write,
    input  logic [31:0] em_read
);

    state_e                state;
    req_t                  req;
    logic [4*ADDR_W-1:0]   lane_addr;
    logic                  fault;
    logic [31:0]           load_ext;
    logic [31:0]           load_data;
    logic                  in_issue;

    lsu_lane_addr #(.MemSize(MemSize)) u_lane_addr (
        .addr      (req.addr),
        .size      (req.size),
        .lane_addr (lane_addr),
        .fault     (fault)
    );

    always_comb begin
        load_ext = '0;
        case (req.size)
            SZ_BYTE: load_ext = {{24{req.sign & em_read[7]}},  em_read[7:0]};
            SZ_HALF: load_ext = {{16{req.sign & em_read[15]}}, em_read[15:0]};
            SZ_WORD: load_ext = em_read;
            default: load_ext = '0;
        endcase
    end

    assign load_data = (!req.write && !fault) ? load_ext : 32'd0;

    // Bus is decoded from the registered state, so an async reset clears it at once.
    assign in_issue   = (state == ISSUE);
    assign em_control = (in_issue && req.write && !fault) ? req.size : 2'd0;
    assign em_address = in_issue ? lane_addr : '0;
    assign em_write   = in_issue ? (req.wdata & byte_mask(req.size)) : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req.write <= req_write;
                        req.size  <= size_e'(req_size);
                        req.sign  <= req_signed;
                        req.addr  <= req_addr;
                        req.wdata <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= ISSUE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= load_data;
                    rsp_fault <= fault;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array memory and reference model.
module tb_load_store_unit;

    localparam int MEM = 125;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [9:0]  req_addr = 10'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic [1:0]  em_control;
    logic [39:0] em_address;
    logic [31:0] em_write;
    logic [31:0] em_read;

    load_store_unit #(.MemSize(MEM)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_fault  (rsp_fault),
        .em_control (em_control),
        .em_address (em_address),
        .em_write   (em_write),
        .em_read    (em_read)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem     [MEM];
    logic [7:0]  ref_mem [MEM];
    logic        mem_ok;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_data = 32'd0;
    logic        last_fault = 1'b0;
    longint      prev_acc = -1;

    function automatic int nb_of(input logic [1:0] s);
        return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : (s == 2'd3) ? 4 : 0;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // External memory: combinational read, write on the rising edge when em_control != 0.
    always_comb begin
        mem_ok  = 1'b1;
        em_read = 32'd0;
        for (int i = 0; i < 4; i++)
            if (int'(em_address[i*10 +: 10]) >= MEM) mem_ok = 1'b0;
        if (mem_ok)
            for (int i = 0; i < 4; i++) em_read[i*8 +: 8] = mem[int'(em_address[i*10 +: 10])];
    end

    always @(posedge clock) begin
        if (em_control != 2'd0)
            for (int i = 0; i < nb_of(em_control); i++)
                if (int'(em_address[i*10 +: 10]) < MEM)
                    mem[int'(em_address[i*10 +: 10])] <= em_write[i*8 +: 8];
    end

    // Reference model: byte array with plain arithmetic for range, extension and bus shape.
    task automatic model(input logic w, input logic [1:0] s, input logic sg, input int a,
                         input logic [31:0] d, output exp_t e, output logic [1:0] ctl,
                         output logic [39:0] ea, output logic [31:0] ew);
        int     nb;
        longint v;
        nb      = nb_of(s);
        e.fault = (nb > 0) && (a + nb - 1 >= MEM);
        e.data  = 32'd0;
        if (!e.fault && nb > 0) begin
            if (w) begin
                for (int i = 0; i < nb; i++) ref_mem[a+i] = d[i*8 +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v + (longint'(ref_mem[a+i]) << (8*i));
                if (sg && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
                e.data = v[31:0];
            end
        end
        ctl = (w && !e.fault) ? s : 2'd0;
        ew  = 32'd0;
        for (int i = 0; i < nb; i++) ew[i*8 +: 8] = d[i*8 +: 8];
        ea  = 40'd0;
        for (int i = 0; i < 4; i++)
            ea[i*10 +: 10] = 10'((a + ((i < nb) ? i : nb - 1)) % 1024);
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        ok = req_ready;
        if (!ok) check("accept_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic do_req(input logic w, input logic [1:0] s, input logic sg, input int a,
                          input logic [31:0] d, input bit keep);
        exp_t        e;
        logic [1:0]  ctl;
        logic [39:0] ea;
        logic [31:0] ew;
        bit          ok;
        req_write = w; req_size = s; req_signed = sg; req_addr = 10'(a); req_wdata = d;
        req_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        if (keep && prev_acc >= 0) check("accept_spacing", 64'($time - prev_acc), 64'd30);
        prev_acc = keep ? longint'($time) : -1;
        model(w, s, sg, a, d, e, ctl, ea, ew);
        q.push_back(e);
        @(negedge clock);
        if (!keep) req_valid = 1'b0;
        check("ready_issue", 64'(req_ready), 64'd0);
        check("em_control", 64'(em_control), 64'(ctl));
        check("em_write", 64'(em_write), 64'(ew));
        if (s != 2'd0) check("em_address", 64'(em_address), 64'(ea));
        @(negedge clock);
        check("ready_resp", 64'(req_ready), 64'd0);
        check("bus_idle", 64'({em_control, em_address, em_write}), 64'd0);
    endtask

    function automatic int rand_addr();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, MEM + 4));
    endfunction

    // Monitor: pop one expectation per response strobe, otherwise the outputs must hold.
    always @(negedge clock) begin
        if (!reset) begin
            last_data  <= 32'd0;
            last_fault <= 1'b0;
        end else if (rsp_valid) begin
            if (q.size() == 0) begin
                check("spurious_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
                last_data  <= e.data;
                last_fault <= e.fault;
            end
        end else begin
            check("rsp_hold", 64'({rsp_fault, rsp_data}), 64'({last_fault, last_data}));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        logic [31:0] saved;
        bit          ok;
        for (int i = 0; i < MEM; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #1 reset = 1'b0;
        #1;
        check("reset_outputs", 64'({rsp_valid, rsp_data, rsp_fault, em_control, em_address, em_write}), 64'd0);
        check("reset_ready", 64'(req_ready), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 64'(req_ready), 64'd1);

        do_req(1'b1, 2'd3, 1'b0, 4, 32'hDEADBEEF, 1'b0);
        check("mem_4_7", 64'({mem[7], mem[6], mem[5], mem[4]}), 64'h0000_0000_DEAD_BEEF);
        do_req(1'b0, 2'd3, 1'b0, 4, 32'd0, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 10, 32'h1234_5680, 1'b0);
        do_req(1'b0, 2'd1, 1'b1, 10, 32'd0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 10, 32'd0, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 124, 32'hA5A5_A55A, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 124, 32'd0, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 122, 32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 2'd3, 1'b0, 122, 32'd0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 123, 32'h0000_8001, 1'b0);
        do_req(1'b0, 2'd2, 1'b1, 123, 32'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 124, 32'd0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 20, 32'hFFFF_FFFF, 1'b0);
        do_req(1'b0, 2'd3, 1'b0, 1023, 32'd0, 1'b0);

        for (int k = 0; k < 30; k++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom, 1'b1);
        req_valid = 1'b0;
        prev_acc  = -1;

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            do_req(1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom, 1'b0);
        end

        // Reset during ISSUE of a word store: nothing may be committed or answered.
        @(negedge clock);
        saved = {mem[3], mem[2], mem[1], mem[0]};
        req_write = 1'b1; req_size = 2'd3; req_signed = 1'b0; req_addr = 10'd0; req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        wait_ready(ok);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("rst_issue_ctl", 64'(em_control), 64'd3);
        #1 reset = 1'b0;
        #1;
        check("rst_issue_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_fault, em_control, em_address, em_write}), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check("rst_mem_0_3", 64'({mem[3], mem[2], mem[1], mem[0]}), 64'(saved));
        @(negedge clock);
        check("rst_ready_release", 64'(req_ready), 64'd1);
        do_req(1'b0, 2'd3, 1'b0, 0, 32'd0, 1'b0);

        // Reset just after the response strobe rises: it must drop at once.
        req_write = 1'b0; req_size = 2'd1; req_addr = 10'd5; req_valid = 1'b1;
        wait_ready(ok);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst_resp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 10; k++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom, 1'b0);

        repeat (5) @(negedge clock);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
